// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: defaults, receiver states,
// ASCII hex ranges and status flag bit positions.
package uart_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefUartNbit  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam logic [7:0] AsciiZero   = 8'h30;
    localparam logic [7:0] AsciiNine   = 8'h39;
    localparam logic [7:0] AsciiUpperA = 8'h41;
    localparam logic [7:0] AsciiUpperF = 8'h46;
    localparam logic [7:0] AsciiLowerA = 8'h61;
    localparam logic [7:0] AsciiLowerF = 8'h66;
    localparam logic [7:0] AsciiLf     = 8'h0A;
    localparam logic [7:0] AsciiCr     = 8'h0D;

    localparam int unsigned FlagWordReady = 0;
    localparam int unsigned FlagOverrun   = 1;
    localparam int unsigned FlagCharError = 2;

    // Returns {valid, nibble}; valid is 0 for anything that is not a hex digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = '0;
        if (c >= AsciiZero && c <= AsciiNine) begin
            r = {1'b1, 4'(c - AsciiZero)};
        end else if (c >= AsciiUpperA && c <= AsciiUpperF) begin
            r = {1'b1, 4'(c - AsciiUpperA + 8'd10)};
        end else if (c >= AsciiLowerA && c <= AsciiLowerF) begin
            r = {1'b1, 4'(c - AsciiLowerA + 8'd10)};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level UART receiver: synchronizes the line, frames one character and
// emits a one-cycle byte_valid for characters with a good stop bit.
module uart_rx_byte import uart_pkg::*; #(
    parameter int unsigned UART_NBIT = DefUartNbit,
    parameter int unsigned CLK_FREQ  = 50,
    parameter int unsigned BAUDRATE  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [UART_NBIT-1:0] rx_byte,
    output logic                 byte_valid
);

    localparam int unsigned BitClks  = CLK_FREQ / BAUDRATE;
    localparam int unsigned HalfClks = BitClks / 2;
    localparam int unsigned CntW     = (BitClks > 1) ? $clog2(BitClks) : 1;
    localparam int unsigned BitW     = (UART_NBIT > 1) ? $clog2(UART_NBIT) : 1;

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q;
    logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [UART_NBIT-1:0] shift_q, shift_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 rx_s;
    logic                 sample_tick;

    assign rx_s = sync_q[1];

    // Start bit is checked half a bit in, every later sample is a full bit apart.
    always_comb begin
        if (state_q == StStart) begin
            sample_tick = (clk_cnt_q == CntW'(HalfClks - 1));
        end else begin
            sample_tick = (clk_cnt_q == CntW'(BitClks - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!rx_s) state_d = StStart;
            StStart: if (sample_tick) state_d = rx_s ? StIdle : StData;
            StData:  if (sample_tick && bit_cnt_q == BitW'(UART_NBIT - 1)) state_d = StStop;
            StStop:  if (sample_tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
            StStart: if (sample_tick) clk_cnt_d = '0;
            StData: begin
                if (sample_tick) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[UART_NBIT-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (sample_tick) begin
                    clk_cnt_d    = '0;
                    byte_valid_d = rx_s;
                end
            end
            default: clk_cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= 2'b11;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], serial_in};
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Assembles ASCII hex characters from a UART line into DATA_WIDTH-bit words,
// tracking word_ready, overrun and char_error status.
module uart_rx_word_assembler import uart_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned UART_NBIT  = DefUartNbit,
    parameter int unsigned CLK_FREQ   = 50,
    parameter int unsigned BAUDRATE   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  clr_rx_flag,
    output logic [DATA_WIDTH-1:0] rx_word,
    output logic [DATA_WIDTH-1:0] rx_flag_out
);

    localparam int unsigned NumNibs = DATA_WIDTH / 4;
    localparam int unsigned NibW    = $clog2(NumNibs);

    logic [UART_NBIT-1:0]  rx_byte;
    logic                  byte_valid;
    logic [7:0]            rx_char;
    logic [4:0]            dec;
    logic                  is_eol;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [NibW-1:0]       nib_cnt_q, nib_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  ready_q, ready_d;
    logic                  overrun_q, overrun_d;
    logic                  char_err_q, char_err_d;

    uart_rx_byte #(
        .UART_NBIT (UART_NBIT),
        .CLK_FREQ  (CLK_FREQ),
        .BAUDRATE  (BAUDRATE)
    ) u_rx_byte (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid)
    );

    assign rx_char = 8'(rx_byte);
    assign dec     = hex_decode(rx_char);
    assign is_eol  = (rx_char == AsciiCr) || (rx_char == AsciiLf);

    // The clear is applied first so that an event in the same cycle wins.
    always_comb begin
        shift_d    = shift_q;
        nib_cnt_d  = nib_cnt_q;
        word_d     = word_q;
        ready_d    = clr_rx_flag & ready_q;
        overrun_d  = clr_rx_flag & overrun_q;
        char_err_d = clr_rx_flag & char_err_q;
        if (byte_valid && !is_eol) begin
            if (dec[4]) begin
                shift_d = {shift_q[DATA_WIDTH-5:0], dec[3:0]};
                if (nib_cnt_q == NibW'(NumNibs - 1)) begin
                    word_d    = shift_d;
                    nib_cnt_d = '0;
                    overrun_d = overrun_d | ready_d;
                    ready_d   = 1'b1;
                end else begin
                    nib_cnt_d = nib_cnt_q + 1'b1;
                end
            end else begin
                shift_d    = '0;
                nib_cnt_d  = '0;
                char_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q    <= '0;
            nib_cnt_q  <= '0;
            word_q     <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            char_err_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            nib_cnt_q  <= nib_cnt_d;
            word_q     <= word_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            char_err_q <= char_err_d;
        end
    end

    always_comb begin
        rx_flag_out                = '0;
        rx_flag_out[FlagWordReady] = ready_q;
        rx_flag_out[FlagOverrun]   = overrun_q;
        rx_flag_out[FlagCharError] = char_err_q;
    end

    assign rx_word = word_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Bench for uart_rx_word_assembler: serial characters in, every change of
// {rx_word, rx_flag_out} is matched against a queue of expected states.
module tb_uart_rx_word_assembler;

    localparam int BitClks = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        serial_in = 1'b1;
    logic        clr_rx_flag = 1'b1;
    logic [31:0] rx_word;
    logic [31:0] rx_flag_out;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] flags;
    } obs_t;

    obs_t exp_q[$];
    obs_t last_obs = '0;
    bit   mon_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_rx_word_assembler #(
        .DATA_WIDTH (32),
        .UART_NBIT  (8),
        .CLK_FREQ   (50),
        .BAUDRATE   (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .clr_rx_flag (clr_rx_flag),
        .rx_word     (rx_word),
        .rx_flag_out (rx_flag_out)
    );

    // Every observed output change must match the oldest pending expectation.
    always @(negedge clk) begin : monitor
        obs_t cur;
        obs_t e;
        if (mon_en) begin
            cur = {rx_word, rx_flag_out};
            if (cur !== last_obs) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: got word=%h flags=%h, required word=%h flags=%h",
                             cur.word, cur.flags, last_obs.word, last_obs.flags);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_err++;
                        $display("FAIL scoreboard: got word=%h flags=%h, required word=%h flags=%h",
                                 cur.word, cur.flags, e.word, e.flags);
                    end
                end
                last_obs = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] word, input logic [31:0] flags);
        exp_q.push_back({word, flags});
    endtask

    task automatic send_char(input logic [7:0] c, input logic stop_bit);
        serial_in = 1'b0;
        tick(BitClks);
        for (int i = 0; i < 8; i++) begin
            serial_in = c[i];
            tick(BitClks);
        end
        serial_in = stop_bit;
        tick(BitClks);
        serial_in = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
    endtask

    task automatic pulse_clear;
        clr_rx_flag = 1'b0;
        tick(1);
        clr_rx_flag = 1'b1;
        tick(2);
    endtask

    task automatic test_reset;
        tick(3);
        n_vec++;
        if (rx_word !== 32'h0) begin
            n_err++;
            $display("FAIL reset_word: got %h, required 00000000", rx_word);
        end
        n_vec++;
        if (rx_flag_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_flags: got %h, required 00000000", rx_flag_out);
        end
        reset = 1'b1;
        tick(2);
        last_obs = '0;
        mon_en = 1'b1;
    endtask

    task automatic test_deadbeef;
        push_exp(32'hDEADBEEF, 32'h1);
        send_str("DEADBEEF");
        tick(BitClks);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_deadbeef: pending %0d, required 0", exp_q.size());
            exp_q.delete();
        end
        push_exp(32'hDEADBEEF, 32'h0);
        pulse_clear();
    endtask

    task automatic test_crlf;
        push_exp(32'h0BADC0DE, 32'h1);
        send_str("0bad\r\nc0de\r\n");
        tick(BitClks);
        push_exp(32'h0BADC0DE, 32'h0);
        pulse_clear();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_crlf: pending %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_char_error;
        push_exp(32'h0BADC0DE, 32'h4);
        send_str("12G");
        push_exp(32'h00000001, 32'h5);
        send_str("00000001");
        tick(BitClks);
        push_exp(32'h00000001, 32'h0);
        pulse_clear();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_char_error: pending %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_framing;
        push_exp(32'h12345678, 32'h1);
        send_str("1234");
        send_char(8'h41, 1'b0);
        tick(2 * BitClks);
        send_str("5678");
        tick(BitClks);
        push_exp(32'h12345678, 32'h0);
        pulse_clear();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_framing: pending %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        push_exp(32'h11111111, 32'h1);
        push_exp(32'h22222222, 32'h3);
        send_str("1111111122222222");
        tick(BitClks);
        serial_in = 1'b0;
        tick(1);
        serial_in = 1'b1;
        tick(3 * BitClks);
        push_exp(32'h22222222, 32'h0);
        pulse_clear();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_back_to_back: pending %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Clear held low across completion and invalid characters: events win for one cycle.
    task automatic test_clear_collision;
        push_exp(32'h22222222, 32'h4);
        send_str("X");
        tick(BitClks);
        push_exp(32'h22222222, 32'h0);
        clr_rx_flag = 1'b0;
        tick(2);
        push_exp(32'h33333333, 32'h1);
        push_exp(32'h33333333, 32'h0);
        send_str("33333333");
        push_exp(32'h33333333, 32'h4);
        push_exp(32'h33333333, 32'h0);
        send_str("Z");
        tick(BitClks);
        clr_rx_flag = 1'b1;
        tick(2);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_clear_collision: pending %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        push_exp(32'h0, 32'h0);
        send_str("1234");
        serial_in = 1'b0;
        tick(BitClks);
        serial_in = 1'b1;
        tick(BitClks / 2);
        reset = 1'b0;
        tick(2);
        n_vec++;
        if (rx_word !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset_word: got %h, required 00000000", rx_word);
        end
        n_vec++;
        if (rx_flag_out !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset_flags: got %h, required 00000000", rx_flag_out);
        end
        tick(BitClks);
        reset = 1'b1;
        tick(2 * BitClks);
        push_exp(32'hCAFEF00D, 32'h1);
        send_str("CAFEF00D");
        tick(BitClks);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_reset_mid: pending %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_deadbeef();
        test_crlf();
        test_char_error();
        test_framing();
        test_back_to_back();
        test_clear_collision();
        test_reset_mid();
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_assembler.md
UART_RX_WORD_ASSEMBLER -- requirements
Module: uart_rx_word_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: assembled word width.
REQ-002 SHALL have parameter UART_NBIT, default 8: data bits per character.
REQ-003 SHALL have parameters CLK_FREQ, default 50, and BAUDRATE, default 5: bit period BIT_CLKS = CLK_FREQ/BAUDRATE clocks (10 at defaults).
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port serial_in, input, 1: UART line, idle high, asynchronous to clk.
REQ-007 SHALL have port clr_rx_flag, input, 1: active-low clear of all status bits.
REQ-008 SHALL have port rx_word, output, DATA_WIDTH: last completed word.
REQ-009 SHALL have port rx_flag_out, output, DATA_WIDTH: bit0 word_ready, bit1 overrun, bit2 char_error, bits [31:3] zero.

Function
REQ-010 SHALL pass serial_in through a 2-flop synchronizer before any use.
REQ-011 Byte receiver states SHALL be IDLE, START, DATA, STOP; IDLE->START on synchronized low.
REQ-012 START SHALL sample at BIT_CLKS/2; high -> false start, back to IDLE, nothing emitted; low -> DATA.
REQ-013 DATA SHALL sample UART_NBIT bits, LSB first, each BIT_CLKS after the previous sample.
REQ-014 STOP SHALL sample BIT_CLKS after the last data bit; high -> one-cycle byte_valid with the byte on the next clock; low -> framing error, byte discarded, no status change, IDLE.
REQ-015 Receiver SHALL return to IDLE after STOP and accept a start bit on the very next low.
REQ-016 On byte_valid, decode: 0x30-0x39 -> 0-9; 0x41-0x46 and 0x61-0x66 -> 10-15.
REQ-017 0x0D and 0x0A SHALL be ignored: no shift, no count change, no status change.
REQ-018 Valid hex nibble: shift_reg <= {shift_reg[27:0], nibble}, nib_cnt increments; first character lands in bits [31:28].
REQ-019 Any other byte: shift_reg and nib_cnt cleared to 0, char_error set (sticky).
REQ-020 On the 8th nibble (nib_cnt 7): one clock after byte_valid, rx_word <= completed word, word_ready <= 1, nib_cnt <= 0.
REQ-021 Completion with word_ready already 1: rx_word overwritten, overrun set (sticky).
REQ-022 clr_rx_flag low SHALL clear word_ready, overrun and char_error on that clock; rx_word and partial assembly unaffected.
REQ-023 Completion in the same cycle as clr_rx_flag low: rx_word updated, word_ready=1, overrun=0, char_error=0.
REQ-024 Invalid character in the same cycle as clr_rx_flag low: char_error=1, others cleared.
REQ-025 nib_cnt SHALL be 3 bits and wrap only via REQ-019/REQ-020; never counts past 7.

Reset
REQ-026 Reset low SHALL force: receiver IDLE, synchronizer flops 1, bit/clock counters 0, shift_reg 0, nib_cnt 0, rx_word 0, rx_flag_out 0.
REQ-027 Reset asserted mid-character SHALL discard the partial byte and partial word; after release, reception resumes at the next start bit.

Structure
REQ-028 Shared package uart_pkg SHALL hold DATA_WIDTH/UART_NBIT defaults, receiver state encodings, ASCII range constants (0x30, 0x39, 0x41, 0x46, 0x61, 0x66, 0x0A, 0x0D) and flag bit indices (0, 1, 2).
REQ-029 Bit-level reception (REQ-010..REQ-015) SHALL be one sub-module uart_rx_byte (outputs: byte, byte_valid); decode and assembly SHALL stay in the top.

Verification (BIT_CLKS=10)
REQ-030 Send "DEADBEEF" -> rx_word=0xDEADBEEF, rx_flag_out=0x1 one clock after the 8th byte_valid.
REQ-031 Send "0badc0de\r\n", then pulse clr_rx_flag low -> rx_word=0x0BADC0DE, rx_flag_out 0x1 then 0x0; CR/LF cause no change.
REQ-032 Send "12G" then "00000001" -> char_error after 'G' (rx_flag_out=0x4), then rx_word=0x00000001, rx_flag_out=0x5.
REQ-033 Send "1234" plus one byte with stop bit low, then "5678" -> framing byte dropped; rx_word=0x12345678.
REQ-034 Two full words "11111111", "22222222" with no clear -> rx_word=0x22222222, rx_flag_out=0x3; 1-cycle low glitch on serial_in -> no byte.
REQ-035 Reset low mid-bit in the 5th character, then send "CAFEF00D" -> all outputs 0 during reset, then rx_word=0xCAFEF00D.
